// File: rtl/sensor_packet_parser_pkg.sv
// Shared definitions for sensor_packet_parser: state encoding, framing defaults,
// data-word field positions and field extraction helpers.
package sensor_packet_parser_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_TIME_STAMP = 4'd1,
        ST_DATA       = 4'd2,
        ST_FOOTER     = 4'd3,
        ST_DROP       = 4'd4
    } parser_state_t;

    localparam logic [31:0] DEFAULT_HEADER    = 32'hAAAAAAAA;
    localparam logic [31:0] DEFAULT_FOOTER    = 32'h55555555;
    localparam int unsigned DEFAULT_NUM_WORDS = 1024;

    // Data word layout: {10'd0, index[21:12], sample[11:0]}
    localparam int unsigned INDEX_MSB  = 21;
    localparam int unsigned INDEX_LSB  = 12;
    localparam int unsigned SAMPLE_MSB = 11;
    localparam int unsigned SAMPLE_LSB = 0;
    localparam int unsigned INDEX_W    = INDEX_MSB - INDEX_LSB + 1;
    localparam int unsigned SAMPLE_W   = SAMPLE_MSB - SAMPLE_LSB + 1;

    localparam int unsigned COUNT_W = 16;

    function automatic logic [INDEX_W-1:0] word_index(input logic [31:0] word);
        return word[INDEX_MSB:INDEX_LSB];
    endfunction

    function automatic logic [SAMPLE_W-1:0] word_sample(input logic [31:0] word);
        return word[SAMPLE_MSB:SAMPLE_LSB];
    endfunction

endpackage

// File: rtl/sensor_packet_parser_sat_counter.sv
// sat_counter: event counter with synchronous active-low reset that sticks at
// all-ones instead of wrapping.
module sat_counter
    import sensor_packet_parser_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_W
) (
    input  logic             master_clock,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sensor_packet_parser.sv
// sensor_packet_parser: validates HEADER/timestamp/NUM_WORDS data/FOOTER packets on an
// AXIS slave and forwards samples through a 1-deep pixel register.
// Build macro SENSOR_PARSER_INDEX_CHECK_EN enables per-word index checking (err_index).
module sensor_packet_parser
    import sensor_packet_parser_pkg::*;
#(
    parameter logic [31:0] HEADER_VALUE = DEFAULT_HEADER,
    parameter logic [31:0] FOOTER_VALUE = DEFAULT_FOOTER,
    parameter int unsigned NUM_WORDS    = DEFAULT_NUM_WORDS
) (
    input  logic                master_clock,
    input  logic                resetn,

    input  logic [31:0]         s_tdata,
    input  logic                s_tvalid,
    input  logic                s_tlast,
    output logic                s_tready,

    output logic [SAMPLE_W-1:0] pix_data,
    output logic [INDEX_W-1:0]  pix_index,
    output logic                pix_valid,
    input  logic                pix_ready,

    output logic [31:0]         frame_timestamp,
    output logic                frame_done,

    output logic                err_header,
    output logic                err_length,
    output logic                err_footer,
    output logic                err_index,

    output logic [COUNT_W-1:0]  frame_count,
    output logic [COUNT_W-1:0]  error_count,
    output logic [3:0]          dbg_state
);

    localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    parser_state_t    state, state_next;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      shadow_ts;

    logic ready_int;
    logic accept;
    logic last_word;
    logic idx_mismatch;

    logic load_pix, cnt_clear, cnt_inc, ts_load;
    logic done_next, eh_next, el_next, ef_next, ei_next, err_any_next;

    assign dbg_state = state;
    assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));

`ifdef SENSOR_PARSER_INDEX_CHECK_EN
    assign idx_mismatch = (word_index(s_tdata) != INDEX_W'(word_cnt));
`else
    assign idx_mismatch = 1'b0;
`endif

    // Ready is decoded in its own process so the accept term feeding next-state
    // logic does not form a combinational self-dependency.
    always_comb begin
        ready_int = 1'b1;
        if (state == ST_DATA) begin
            ready_int = !pix_valid || pix_ready;
        end
    end

    assign s_tready = resetn && ready_int;
    assign accept   = s_tvalid && s_tready;

    always_comb begin
        state_next = state;
        load_pix   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        ts_load    = 1'b0;
        done_next  = 1'b0;
        eh_next    = 1'b0;
        el_next    = 1'b0;
        ef_next    = 1'b0;
        ei_next    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (s_tdata != HEADER_VALUE) begin
                        eh_next = 1'b1;
                    end else if (s_tlast) begin
                        el_next = 1'b1;
                    end else begin
                        state_next = ST_TIME_STAMP;
                    end
                end
            end

            ST_TIME_STAMP: begin
                if (accept) begin
                    ts_load = 1'b1;
                    if (s_tlast) begin
                        el_next    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_clear  = 1'b1;
                        state_next = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    load_pix = 1'b1;
                    cnt_inc  = 1'b1;
                    // A truncated packet reports only the length error for its last word.
                    if (s_tlast) begin
                        el_next    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ei_next = idx_mismatch;
                        if (last_word) begin
                            state_next = ST_FOOTER;
                        end
                    end
                end
            end

            ST_FOOTER: begin
                if (accept) begin
                    if ((s_tdata == FOOTER_VALUE) && s_tlast) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ef_next    = 1'b1;
                        state_next = s_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end

            ST_DROP: begin
                if (accept && s_tlast) begin
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign err_any_next = eh_next || el_next || ef_next || ei_next;

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            word_cnt  <= '0;
            shadow_ts <= '0;
        end else begin
            if (cnt_clear) begin
                word_cnt <= '0;
            end else if (cnt_inc) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (ts_load) begin
                shadow_ts <= s_tdata;
            end
        end
    end

    // Loads only happen when the slot is empty or draining, so a held pixel is never overwritten.
    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_index <= '0;
        end else if (load_pix) begin
            pix_valid <= 1'b1;
            pix_data  <= word_sample(s_tdata);
            pix_index <= word_index(s_tdata);
        end else if (pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            frame_timestamp <= '0;
            frame_done      <= 1'b0;
            err_header      <= 1'b0;
            err_length      <= 1'b0;
            err_footer      <= 1'b0;
            err_index       <= 1'b0;
        end else begin
            if (done_next) begin
                frame_timestamp <= shadow_ts;
            end
            frame_done <= done_next;
            err_header <= eh_next;
            err_length <= el_next;
            err_footer <= ef_next;
            err_index  <= ei_next;
        end
    end

    sat_counter #(.WIDTH(COUNT_W)) u_frame_count (
        .master_clock (master_clock),
        .resetn       (resetn),
        .inc          (done_next),
        .count        (frame_count)
    );

    sat_counter #(.WIDTH(COUNT_W)) u_error_count (
        .master_clock (master_clock),
        .resetn       (resetn),
        .inc          (err_any_next),
        .count        (error_count)
    );

endmodule

// File: tb/tb_sensor_packet_parser.sv
// Self-checking bench for sensor_packet_parser: table-driven framing vectors plus
// full-packet sequences with a pixel scoreboard.
module tb_sensor_packet_parser;

    localparam logic [31:0] HDR = 32'hAAAAAAAA;
    localparam logic [31:0] FTR = 32'h55555555;
    localparam int          NW  = 1024;

    logic        master_clock = 1'b0;
    logic        resetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [11:0] pix_data;
    logic [9:0]  pix_index;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] frame_timestamp;
    logic        frame_done;
    logic        err_header, err_length, err_footer, err_index;
    logic [15:0] frame_count, error_count;
    logic [3:0]  dbg_state;

    always #5 master_clock = ~master_clock;

    sensor_packet_parser #(
        .HEADER_VALUE (32'hAAAAAAAA),
        .FOOTER_VALUE (32'h55555555),
        .NUM_WORDS    (1024)
    ) dut (
        .master_clock    (master_clock),
        .resetn          (resetn),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .pix_data        (pix_data),
        .pix_index       (pix_index),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .frame_timestamp (frame_timestamp),
        .frame_done      (frame_done),
        .err_header      (err_header),
        .err_length      (err_length),
        .err_footer      (err_footer),
        .err_index       (err_index),
        .frame_count     (frame_count),
        .error_count     (error_count),
        .dbg_state       (dbg_state)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  st;      // expected dbg_state after the word
        logic [3:0]  pulses;  // {err_header, err_length, err_footer, frame_done}
        logic [15:0] ecnt;    // expected error_count after the word
    } vec_t;

    vec_t vecs [8];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [21:0] exp_q [$];
    logic bp_mode = 1'b0;

    int cnt_done = 0, cnt_eh = 0, cnt_el = 0, cnt_ef = 0, cnt_ei = 0;
    int b_done, b_eh, b_el, b_ef, b_ei;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic snap();
        b_done = cnt_done; b_eh = cnt_eh; b_el = cnt_el; b_ef = cnt_ef; b_ei = cnt_ei;
    endtask

    // All driving tasks start and end at posedge+1.
    task automatic send_word(input logic [31:0] d, input logic l);
        int unsigned waits;
        waits = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge master_clock);
            if (s_tready) break;
            waits++;
            if (waits > 100) begin
                check("tready_timeout", 32'(s_tready), 32'd1);
                break;
            end
        end
        @(posedge master_clock);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    function automatic logic [21:0] pix_of(input int i, input logic [9:0] idx);
        logic [11:0] smp;
        smp = 12'(i * 37 + 5);
        return {idx, smp};
    endfunction

    task automatic send_data(input int i, input logic [9:0] idx, input logic l);
        logic [21:0] p;
        p = pix_of(i, idx);
        exp_q.push_back(p);
        send_word({10'd0, p}, l);
    endtask

    task automatic send_packet(input logic [31:0] ts, input int tlast_at, input int bad_idx_at,
                               input logic [31:0] footer, input logic footer_last);
        logic [9:0] idx;
        send_word(HDR, 1'b0);
        send_word(ts, 1'b0);
        for (int i = 0; i < NW; i++) begin
            idx = (i == bad_idx_at) ? 10'd9 : 10'(i);
            send_data(i, idx, i == tlast_at);
            if (i == 0) begin
                check("latency_pix_valid", 32'(pix_valid), 32'd1);
                check("latency_pix_index", 32'(pix_index), 32'd0);
            end
            if (i == tlast_at) return;
        end
        send_word(footer, footer_last);
    endtask

    task automatic check_reset_outputs();
        check("rst_tready", 32'(s_tready), 32'd0);
        check("rst_pix", {9'd0, pix_valid, pix_index, pix_data}, 32'd0);
        check("rst_pulses", {27'd0, frame_done, err_header, err_length, err_footer, err_index}, 32'd0);
        check("rst_counters", {frame_count, error_count}, 32'd0);
        check("rst_timestamp", frame_timestamp, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge master_clock);
        #1;
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        repeat (2) @(posedge master_clock);
        @(negedge master_clock);
        check_reset_outputs();
        exp_q.delete();
        resetn = 1'b1;
        #1;
        check("tready_after_release", 32'(s_tready), 32'd1);
        @(posedge master_clock);
        #1;
        snap();
    endtask

    task automatic finish_scn();
        int unsigned k;
        k = 0;
        while (exp_q.size() != 0 && k < 64) begin
            @(posedge master_clock);
            k++;
        end
        check("pix_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge master_clock);
        @(posedge master_clock);
        #1;
    endtask

    task automatic pix_monitor();
        logic        held;
        logic [21:0] hv;
        logic [21:0] e;
        held = 1'b0;
        hv   = '0;
        forever begin
            @(negedge master_clock);
            if (frame_done) cnt_done++;
            if (err_header) cnt_eh++;
            if (err_length) cnt_el++;
            if (err_footer) cnt_ef++;
            if (err_index)  cnt_ei++;
            if (!resetn) begin
                held = 1'b0;
                continue;
            end
            if (held) check("pix_hold_stable", {9'd0, pix_valid, pix_index, pix_data}, {9'd0, 1'b1, hv});
            held = 1'b0;
            if (pix_valid && pix_ready) begin
                check("pix_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pix_order", {10'd0, pix_index, pix_data}, {10'd0, e});
                end
            end else if (pix_valid) begin
                held = 1'b1;
                hv   = {pix_index, pix_data};
                if (dbg_state == 4'd2) check("tready_low_while_held", 32'(s_tready), 32'd0);
            end
        end
    endtask

    task automatic ready_gen();
        int unsigned c;
        c = 0;
        forever begin
            @(posedge master_clock);
            #1;
            c++;
            pix_ready = bp_mode ? (c % 3 == 0) : 1'b1;
        end
    endtask

    initial begin
        resetn    = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        pix_ready = 1'b1;

        vecs[0] = '{32'h00000001, 1'b0, 4'd0, 4'b1000, 16'd1};
        vecs[1] = '{HDR,          1'b1, 4'd0, 4'b0100, 16'd2};
        vecs[2] = '{32'h12345678, 1'b1, 4'd0, 4'b1000, 16'd3};
        vecs[3] = '{HDR,          1'b0, 4'd1, 4'b0000, 16'd3};
        vecs[4] = '{32'h0000BEEF, 1'b1, 4'd0, 4'b0100, 16'd4};
        vecs[5] = '{HDR,          1'b0, 4'd1, 4'b0000, 16'd4};
        vecs[6] = '{32'h11111111, 1'b1, 4'd0, 4'b0100, 16'd5};
        vecs[7] = '{FTR,          1'b0, 4'd0, 4'b1000, 16'd6};

        fork
            pix_monitor();
            ready_gen();
        join_none

        // Framing vectors from IDLE / TIME_STAMP
        do_reset();
        for (int v = 0; v < 8; v++) begin
            send_word(vecs[v].data, vecs[v].last);
            check($sformatf("vec%0d_state", v), 32'(dbg_state), 32'(vecs[v].st));
            check($sformatf("vec%0d_pulses", v), {28'd0, err_header, err_length, err_footer, frame_done},
                  32'(vecs[v].pulses));
            check($sformatf("vec%0d_errcnt", v), 32'(error_count), 32'(vecs[v].ecnt));
        end
        check("vec_frame_count", 32'(frame_count), 32'd0);

        // Good packet, no backpressure
        do_reset();
        send_packet(32'h12345678, -1, -1, FTR, 1'b1);
        check("good_done_latency", 32'(frame_done), 32'd1);
        check("good_timestamp", frame_timestamp, 32'h12345678);
        finish_scn();
        check("good_frame_count", 32'(frame_count), 32'd1);
        check("good_error_count", 32'(error_count), 32'd0);
        check("good_done_pulses", 32'(cnt_done - b_done), 32'd1);

        // Same packet, pix_ready high one cycle in three
        do_reset();
        bp_mode = 1'b1;
        send_packet(32'h12345678, -1, -1, FTR, 1'b1);
        finish_scn();
        bp_mode = 1'b0;
        check("bp_frame_count", 32'(frame_count), 32'd1);
        check("bp_timestamp", frame_timestamp, 32'h12345678);
        check("bp_done_pulses", 32'(cnt_done - b_done), 32'd1);

        // tlast on data word 500, then a good packet
        do_reset();
        send_packet(32'h0BADBAD0, 500, -1, FTR, 1'b1);
        check("trunc_state", 32'(dbg_state), 32'd0);
        finish_scn();
        check("trunc_err_length", 32'(cnt_el - b_el), 32'd1);
        check("trunc_error_count", 32'(error_count), 32'd1);
        check("trunc_ts_unchanged", frame_timestamp, 32'd0);
        send_packet(32'h00C0FFEE, -1, -1, FTR, 1'b1);
        finish_scn();
        check("trunc_next_done", 32'(cnt_done - b_done), 32'd1);
        check("trunc_next_frames", 32'(frame_count), 32'd1);
        check("trunc_next_ts", frame_timestamp, 32'h00C0FFEE);

        // Bad footer without tlast, junk, then tlast
        do_reset();
        send_packet(32'h13572468, -1, -1, 32'hDEADBEEF, 1'b0);
        check("ftr_state_drop", 32'(dbg_state), 32'd4);
        check("ftr_err_pulse", 32'(err_footer), 32'd1);
        send_word(32'h00000000, 1'b0);
        send_word(HDR, 1'b0);
        check("ftr_still_drop", 32'(dbg_state), 32'd4);
        send_word(32'h0000FFFF, 1'b1);
        check("ftr_back_idle", 32'(dbg_state), 32'd0);
        finish_scn();
        check("ftr_err_count", 32'(cnt_ef - b_ef), 32'd1);
        check("ftr_error_count", 32'(error_count), 32'd1);
        check("ftr_frames", 32'(frame_count), 32'd0);
        check("ftr_ts_unchanged", frame_timestamp, 32'd0);

        // Garbage before header, good packet, then reset mid-packet
        do_reset();
        send_word(32'h00000001, 1'b0);
        check("garb_err_header", 32'(err_header), 32'd1);
        send_packet(32'h2468ACE0, -1, -1, FTR, 1'b1);
        finish_scn();
        check("garb_frames", 32'(frame_count), 32'd1);
        check("garb_error_count", 32'(error_count), 32'd1);
        check("garb_ts", frame_timestamp, 32'h2468ACE0);
        send_word(HDR, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 300; i++) send_data(i, 10'(i), 1'b0);
        s_tdata  = {10'd0, pix_of(300, 10'd300)};
        s_tvalid = 1'b1;
        resetn   = 1'b0;
        @(negedge master_clock);
        check("midrst_tready", 32'(s_tready), 32'd0);
        @(posedge master_clock);
        @(negedge master_clock);
        check_reset_outputs();
        exp_q.delete();
        s_tvalid = 1'b0;
        resetn   = 1'b1;
        #1;
        check("midrst_tready_release", 32'(s_tready), 32'd1);
        @(posedge master_clock);
        #1;
        snap();
        send_word({10'd0, pix_of(300, 10'd300)}, 1'b0);
        send_word({10'd0, pix_of(301, 10'd301)}, 1'b0);
        send_word({10'd0, pix_of(302, 10'd302)}, 1'b1);
        finish_scn();
        check("resync_err_header", 32'(cnt_eh - b_eh), 32'd3);
        check("resync_error_count", 32'(error_count), 32'd3);
        send_packet(32'h0F0F0F0F, -1, -1, FTR, 1'b1);
        finish_scn();
        check("resync_frames", 32'(frame_count), 32'd1);
        check("resync_ts", frame_timestamp, 32'h0F0F0F0F);

        // Word 7 carries index 9
        do_reset();
        send_packet(32'h77777777, -1, 7, FTR, 1'b1);
        finish_scn();
        check("idx_done", 32'(cnt_done - b_done), 32'd1);
        check("idx_frames", 32'(frame_count), 32'd1);
`ifdef SENSOR_PARSER_INDEX_CHECK_EN
        check("idx_err_index", 32'(cnt_ei - b_ei), 32'd1);
        check("idx_error_count", 32'(error_count), 32'd1);
`else
        check("idx_err_index", 32'(cnt_ei - b_ei), 32'd0);
        check("idx_error_count", 32'(error_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
